// File: rtl/risc_pkg.sv
// Shared definitions for the writeback stage.
// Contents:
//   XLEN     - default register data width
//   NREG     - default number of architectural registers
//   REG_IDX_W - register index width derived from NREG
//   wb_src_e - identifies which result source owns a writeback grant
package risc_pkg;

   localparam int XLEN      = 32;
   localparam int NREG      = 32;
   localparam int REG_IDX_W = $clog2(NREG);

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register with valid/ready on the input side and a grant
// input that drains the entry. A new entry may be accepted in the same
// cycle the held one is granted, giving one transfer per cycle.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - offer handshake (transfer when both high at edge)
//   in_rd, in_dat     - offered destination index and data
//   grant             - the held entry is consumed at the next edge
//   full              - slot currently holds an entry
//   rd, dat           - held destination index and data
module wb_slot #(
   parameter int XLEN = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_rd,
   input  logic [XLEN-1:0]  in_dat,
   input  logic             grant,
   output logic             full,
   output logic [IDX_W-1:0] rd,
   output logic [XLEN-1:0]  dat
);

   logic             full_r;
   logic [IDX_W-1:0] rd_r;
   logic [XLEN-1:0]  dat_r;
   logic             accept_s;

   // Ready whenever the slot is empty or its entry leaves this cycle.
   always_comb begin
      in_ready = ~full_r | grant;
      accept_s = in_valid & in_ready;
   end

   // Slot occupancy and payload storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r <= 1'b0;
         rd_r   <= '0;
         dat_r  <= '0;
      end else if (accept_s) begin
         full_r <= 1'b1;
         rd_r   <= in_rd;
         dat_r  <= in_dat;
      end else if (grant) begin
         full_r <= 1'b0;
      end else begin
         full_r <= full_r;
      end
   end

   assign full = full_r;
   assign rd   = rd_r;
   assign dat  = dat_r;

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// ALU and load results each land in their own one-entry slot; one slot is
// granted per cycle (round-robin on ties) and drives a registered
// register-file write port. A busy bit per register tracks issued but not
// yet committed writes.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   alu_valid/alu_ready/rd/dat    - ALU result offer
//   mem_valid/mem_ready/rd/dat    - load result offer
//   iss_valid/iss_rd              - issue marks iss_rd busy
//   q_reg0/q_reg1, busy0/busy1    - scoreboard queries (registered state only)
//   w_reg/w_dat/write             - registered register-file write port
module reg_writeback #(
   parameter int XLEN = risc_pkg::XLEN,
   parameter int NREG = risc_pkg::NREG
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   input  logic [$clog2(NREG)-1:0] alu_rd,
   input  logic [XLEN-1:0]         alu_dat,
   output logic                    alu_ready,
   input  logic                    mem_valid,
   input  logic [$clog2(NREG)-1:0] mem_rd,
   input  logic [XLEN-1:0]         mem_dat,
   output logic                    mem_ready,
   input  logic                    iss_valid,
   input  logic [$clog2(NREG)-1:0] iss_rd,
   input  logic [$clog2(NREG)-1:0] q_reg0,
   input  logic [$clog2(NREG)-1:0] q_reg1,
   output logic                    busy0,
   output logic                    busy1,
   output logic [$clog2(NREG)-1:0] w_reg,
   output logic [XLEN-1:0]         w_dat,
   output logic                    write
);

   import risc_pkg::*;

   localparam int IDX_W = $clog2(NREG);

   logic             alu_full_s;
   logic [IDX_W-1:0] alu_q_rd_s;
   logic [XLEN-1:0]  alu_q_dat_s;
   logic             mem_full_s;
   logic [IDX_W-1:0] mem_q_rd_s;
   logic [XLEN-1:0]  mem_q_dat_s;

   logic             gnt_alu_s;
   logic             gnt_mem_s;
   logic             gnt_any_s;
   logic [IDX_W-1:0] sel_rd_s;
   logic [XLEN-1:0]  sel_dat_s;
   wb_src_e          last_grant_r;

   logic             write_r;
   logic [IDX_W-1:0] w_reg_r;
   logic [XLEN-1:0]  w_dat_r;

   logic [NREG-1:0]  busy_r;
   logic [NREG-1:0]  set_mask_s;
   logic [NREG-1:0]  clr_mask_s;
   logic [NREG-1:0]  busy_nxt_s;

   wb_slot #(.XLEN(XLEN), .IDX_W(IDX_W)) u_alu_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (alu_valid),
      .in_ready (alu_ready),
      .in_rd    (alu_rd),
      .in_dat   (alu_dat),
      .grant    (gnt_alu_s),
      .full     (alu_full_s),
      .rd       (alu_q_rd_s),
      .dat      (alu_q_dat_s)
   );

   wb_slot #(.XLEN(XLEN), .IDX_W(IDX_W)) u_mem_slot (
      .clk      (clk),
      .rst      (rst),
      .in_valid (mem_valid),
      .in_ready (mem_ready),
      .in_rd    (mem_rd),
      .in_dat   (mem_dat),
      .grant    (gnt_mem_s),
      .full     (mem_full_s),
      .rd       (mem_q_rd_s),
      .dat      (mem_q_dat_s)
   );

   // Single-winner arbitration; on a tie the source not granted last wins.
   always_comb begin
      gnt_alu_s = 1'b0;
      gnt_mem_s = 1'b0;
      case ({alu_full_s, mem_full_s})
         2'b10: gnt_alu_s = 1'b1;
         2'b01: gnt_mem_s = 1'b1;
         2'b11: begin
            if (last_grant_r == SRC_ALU) begin
               gnt_mem_s = 1'b1;
            end else begin
               gnt_alu_s = 1'b1;
            end
         end
         default: begin
            gnt_alu_s = 1'b0;
            gnt_mem_s = 1'b0;
         end
      endcase
   end

   // Route the granted slot's payload toward the write port.
   always_comb begin
      gnt_any_s = gnt_alu_s | gnt_mem_s;
      if (gnt_mem_s) begin
         sel_rd_s  = mem_q_rd_s;
         sel_dat_s = mem_q_dat_s;
      end else begin
         sel_rd_s  = alu_q_rd_s;
         sel_dat_s = alu_q_dat_s;
      end
   end

   // Remember which source was granted most recently for tie-breaking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= SRC_ALU;
      end else if (gnt_alu_s) begin
         last_grant_r <= SRC_ALU;
      end else if (gnt_mem_s) begin
         last_grant_r <= SRC_MEM;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   // Registered write port; x0 entries drain without producing a write and
   // leave w_reg/w_dat at their last committed values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_r <= 1'b0;
         w_reg_r <= '0;
         w_dat_r <= '0;
      end else if (gnt_any_s && (sel_rd_s != '0)) begin
         write_r <= 1'b1;
         w_reg_r <= sel_rd_s;
         w_dat_r <= sel_dat_s;
      end else begin
         write_r <= 1'b0;
      end
   end

   // Scoreboard next state: a same-edge issue overrides the commit clear.
   always_comb begin
      set_mask_s = (iss_valid && (iss_rd != '0))
                   ? ({{(NREG-1){1'b0}}, 1'b1} << iss_rd) : '0;
      clr_mask_s = write_r ? ({{(NREG-1){1'b0}}, 1'b1} << w_reg_r) : '0;
      busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s)
                   & ~{{(NREG-1){1'b0}}, 1'b1};
   end

   // Scoreboard state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign busy0 = busy_r[q_reg0];
   assign busy1 = busy_r[q_reg1];
   assign write = write_r;
   assign w_reg = w_reg_r;
   assign w_dat = w_dat_r;

endmodule
